// File: rtl/pixel_out_serializer.sv
// Pixel FIFO plus byte serializer: 1 byte/pixel for narrow modes, 3 bytes (MSB first) in bypass.
// Build option SER_PARITY_EN adds parity_o, the XOR of byte_o.
module pixel_out_serializer #(
  parameter int MAX_PIXEL_BITS = 24,
  parameter int BYTE_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      px_rdy_i,
  input  logic [MAX_PIXEL_BITS-1:0] in_pixel_i,
  input  logic [1:0]                mode_i,
  input  logic                      byte_ready_i,
  output logic [BYTE_WIDTH-1:0]     byte_o,
  output logic                      byte_valid_o,
  output logic                      fifo_full_o,
  output logic                      overflow_o
`ifdef SER_PARITY_EN
  ,
  output logic                      parity_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = MAX_PIXEL_BITS + 1;
  localparam int BW = BYTE_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_MID, SEND_LO} state_t;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [EW-1:0]   head;
  logic [2*BW-1:0] tail;
  logic            push, pop, accept;
  state_t          state;

  always_comb begin
    accept = byte_valid_o && byte_ready_i;
    push   = px_rdy_i && (count != FULL_CNT);
    pop    = (count != '0) && ((state == IDLE) || ((state == SEND_LO) && accept));
    head   = mem[rd_ptr];
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // The wide flag is captured with the pixel so later mode changes cannot affect it.
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) mem[wr_ptr] <= {(mode_i == 2'b11), in_pixel_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fifo_full_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count       <= count_next;
      fifo_full_o <= (count_next == FULL_CNT);
      if (px_rdy_i && (count == FULL_CNT)) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      tail         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tail         <= head[2*BW-1:0];
            byte_valid_o <= 1'b1;
            if (head[MAX_PIXEL_BITS]) begin
              byte_o <= head[3*BW-1 -: BW];
              state  <= SEND_HI;
            end else begin
              byte_o <= head[BW-1:0];
              state  <= SEND_LO;
            end
          end
        end
        SEND_HI: begin
          if (accept) begin
            byte_o <= tail[2*BW-1 -: BW];
            state  <= SEND_MID;
          end
        end
        SEND_MID: begin
          if (accept) begin
            byte_o <= tail[BW-1:0];
            state  <= SEND_LO;
          end
        end
        SEND_LO: begin
          // Chain straight into the next pixel when one is waiting, avoiding an idle bubble.
          if (accept) begin
            if (pop) begin
              tail <= head[2*BW-1:0];
              if (head[MAX_PIXEL_BITS]) begin
                byte_o <= head[3*BW-1 -: BW];
                state  <= SEND_HI;
              end else begin
                byte_o <= head[BW-1:0];
                state  <= SEND_LO;
              end
            end else begin
              byte_o       <= '0;
              byte_valid_o <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SER_PARITY_EN
  assign parity_o = ^byte_o;
`endif

endmodule

// File: tb/tb_pixel_out_serializer.sv
// Directed bench for pixel_out_serializer; define SER_PARITY_EN to also check parity_o.
module tb_pixel_out_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        px_rdy = 1'b0;
  logic [23:0] in_pixel = '0;
  logic [1:0]  mode = 2'b00;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid, fifo_full, overflow;
`ifdef SER_PARITY_EN
  logic        parity;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];
  logic       rdy_pat[$];

  always #5 clk = ~clk;

  pixel_out_serializer dut (
    .clk_i(clk), .reset_i(reset), .px_rdy_i(px_rdy), .in_pixel_i(in_pixel),
    .mode_i(mode), .byte_ready_i(byte_ready), .byte_o(byte_out),
    .byte_valid_o(byte_valid), .fifo_full_o(fifo_full), .overflow_o(overflow)
`ifdef SER_PARITY_EN
    , .parity_o(parity)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_px(input logic [23:0] px, input logic [1:0] m);
    px_rdy = 1'b1; in_pixel = px; mode = m;
  endtask

  // Consumes exp_q byte by byte, applying rdy_pat first and then ready=1.
  task automatic run_drain(input string tag, input int max_cycles);
    int acc = 0;
    int n = exp_q.size();
    for (int cyc = 0; cyc < max_cycles && exp_q.size() != 0; cyc++) begin
      byte_ready = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : 1'b1;
      if (byte_valid) begin
        chk({tag, "_byte"}, byte_out, exp_q[0]);
`ifdef SER_PARITY_EN
        chk({tag, "_par"}, parity, ^exp_q[0]);
`endif
        if (byte_ready) begin
          void'(exp_q.pop_front());
          acc++;
        end
      end
      tick();
    end
    chk({tag, "_accepts"}, acc, n);
    byte_ready = 1'b0;
    chk({tag, "_idle"}, byte_valid, 0);
  endtask

  initial begin
    tick(); tick();
    chk("rst_byte", byte_out, 0);
    chk("rst_valid", byte_valid, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    tick();

    // Narrow: two back-to-back pixels, no bubble between bytes.
    byte_ready = 1'b1;
    drive_px(24'h00005A, 2'b00);
    tick();
    chk("nar_lat0", byte_valid, 0);
    drive_px(24'h00003C, 2'b00);
    tick();
    px_rdy = 1'b0;
    chk("nar_v1", byte_valid, 1);
    chk("nar_b1", byte_out, 8'h5A);
    tick();
    chk("nar_v2", byte_valid, 1);
    chk("nar_b2", byte_out, 8'h3C);
    tick();
    chk("nar_end", byte_valid, 0);
    byte_ready = 1'b0;

    // Wide with backpressure.
    drive_px(24'h112233, 2'b11);
    tick();
    px_rdy = 1'b0;
    chk("wide_lat0", byte_valid, 0);
    tick();
    exp_q = '{8'h11, 8'h22, 8'h33};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_drain("wide", 20);

    // Mode is captured at push time.
    drive_px(24'hAABBCC, 2'b11);
    tick();
    drive_px(24'h000077, 2'b01);
    tick();
    px_rdy = 1'b0;
    mode = 2'b11;
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'h77};
    run_drain("mode", 20);

    // Overflow: one pixel parked in the serializer, then five pushes into the FIFO.
    drive_px(24'h0000E0, 2'b00);
    tick();
    px_rdy = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      drive_px(24'(i), 2'b00);
      tick();
      if (i == 3) chk("ovf_full3", fifo_full, 0);
      if (i == 4) begin
        chk("ovf_full4", fifo_full, 1);
        chk("ovf_flag4", overflow, 0);
      end
    end
    px_rdy = 1'b0;
    chk("ovf_full5", fifo_full, 1);
    chk("ovf_flag5", overflow, 1);
    exp_q = '{8'hE0, 8'h01, 8'h02, 8'h03, 8'h04};
    run_drain("ovf", 30);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_notfull", fifo_full, 0);

    // Reset mid-transfer with a second pixel still queued.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    drive_px(24'h445566, 2'b11);
    tick();
    drive_px(24'h778899, 2'b11);
    tick();
    px_rdy = 1'b0;
    byte_ready = 1'b1;
    chk("mid_b0", byte_out, 8'h44);
    tick();
    byte_ready = 1'b0;
    chk("mid_b1", byte_out, 8'h55);
    reset = 1'b1;
    tick(); tick();
    chk("mrst_byte", byte_out, 0);
    chk("mrst_valid", byte_valid, 0);
    chk("mrst_full", fifo_full, 0);
    chk("mrst_ovf", overflow, 0);
`ifdef SER_PARITY_EN
    chk("mrst_par", parity, 0);
`endif
    reset = 1'b0;
    tick(); tick();
    chk("mrst_empty", byte_valid, 0);
    drive_px(24'hA1B2C3, 2'b11);
    tick();
    px_rdy = 1'b0;
    tick();
    exp_q = '{8'hA1, 8'hB2, 8'hC3};
    run_drain("post_rst", 20);

`ifdef SER_PARITY_EN
    drive_px(24'h000003, 2'b00);
    tick();
    drive_px(24'h000007, 2'b00);
    tick();
    px_rdy = 1'b0;
    exp_q = '{8'h03, 8'h07};
    run_drain("par", 20);
    chk("par_idle", parity, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
